alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: one request in, one registered result + NZCV flags out.
// Latency 1 cycle for ADD/SUB/AND/OR/MOV/LSL/LSR, N cycles for MUL (shift-add).
// Result is held until ready_i; ready_o is low while multiplying or while a held result is not taken.
module alu_seq #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   opcode_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [N-1:0] result_o,
    output logic [3:0]   ALUFlags,
    output logic         valid_o,
    input  logic         ready_i
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MOV = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    op_e           op;
    logic          accept;
    logic          mul_last;
    logic [SW-1:0] cnt_q;
    logic [N-1:0]  acc_q, mcand_q, mplier_q, acc_sum;

    logic [SW-1:0] shamt;
    logic [N-1:0]  b_eff;
    logic [N:0]    sum, shl, shr;
    logic [N-1:0]  alu_res;
    logic          alu_c, alu_v;

    assign op    = op_e'(opcode_i);
    assign shamt = b_i[SW-1:0];
    assign b_eff = (op == OP_SUB) ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, (op == OP_SUB)};
    // Extra bit on the exit side of each shifter catches the last bit shifted out.
    assign shl   = {1'b0, a_i} << shamt;
    assign shr   = {a_i, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            OP_AND: alu_res = a_i & b_i;
            OP_OR:  alu_res = a_i | b_i;
            OP_MOV: alu_res = a_i;
            OP_LSL: begin
                alu_res = shl[N-1:0];
                alu_c   = shl[N];
            end
            OP_LSR: begin
                alu_res = shr[N:1];
                alu_c   = shr[0];
            end
            default: alu_res = '0;
        endcase
    end

    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (state_q == BUSY) && (cnt_q == SW'(N - 1));

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            IDLE: ready_o = 1'b1;
            HOLD: ready_o = ready_i;
            default: ready_o = 1'b0;
        endcase
        accept = valid_i && ready_o;
        case (state_q)
            IDLE, HOLD: begin
                if (accept)
                    state_d = (op == OP_MUL) ? BUSY : HOLD;
                else if (state_q == HOLD && ready_i)
                    state_d = IDLE;
            end
            BUSY: if (mul_last) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Multiplicand walks left, multiplier walks right; one partial product per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept && op == OP_MUL) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (state_q == BUSY) begin
            cnt_q    <= cnt_q + SW'(1);
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            ALUFlags <= '0;
        end else if (accept && op != OP_MUL) begin
            valid_o  <= 1'b1;
            result_o <= alu_res;
            ALUFlags <= {alu_res[N-1], (alu_res == '0), alu_c, alu_v};
        end else if (mul_last) begin
            valid_o  <= 1'b1;
            result_o <= acc_sum;
            ALUFlags <= {acc_sum[N-1], (acc_sum == '0), 2'b00};
        end else if (state_q == HOLD && ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (N=8): directed literal cases plus random traffic against a transaction-level model.
module tb_alu_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic [2:0]   opc = '0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         ready_o, valid_o;
    logic [N-1:0] result_o;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    alu_seq #(.N(N)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .a_i      (a),
        .b_i      (b),
        .opcode_i (opc),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .result_o (result_o),
        .ALUFlags (flags),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference arithmetic from the operation definitions; flags packed {N,Z,C,V}.
    function automatic void ref_op(input logic [2:0] o, input longint x, input longint y,
                                   output longint r, output logic [3:0] f);
        longint mask, s, full, sx, sy, lim;
        bit c, v;
        mask = (longint'(1) << N) - 1;
        lim  = longint'(1) << (N - 1);
        s    = y % N;
        sx   = (x >= lim) ? x - (longint'(1) << N) : x;
        sy   = (y >= lim) ? y - (longint'(1) << N) : y;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (o)
            3'd0: begin
                full = x + y;
                r = full & mask;
                c = ((full >> N) & 1) != 0;
                v = (sx + sy >= lim) || (sx + sy < -lim);
            end
            3'd1: begin
                r = (x - y) & mask;
                c = (x >= y);
                v = (sx - sy >= lim) || (sx - sy < -lim);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x;
            3'd5: begin
                r = (x << s) & mask;
                c = (s != 0) && (((x >> (N - s)) & 1) != 0);
            end
            3'd6: begin
                r = x >> s;
                c = (s != 0) && (((x >> (s - 1)) & 1) != 0);
            end
            default: r = (x * y) & mask;
        endcase
        f = {((r >> (N - 1)) & 1) != 0, r == 0, c, v};
    endfunction

    // Model: a held result (m_valid) and a countdown of cycles until a pending product appears.
    bit       m_valid = 1'b0;
    longint   m_res = 0, p_res = 0;
    logic [3:0] m_flags = '0, p_flags = '0;
    int       m_wait = 0;

    function automatic bit m_rdy();
        return (m_wait == 0) && (!m_valid || ready_i);
    endfunction

    initial forever begin
        longint r;
        logic [3:0] f;
        bit rdy;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0; m_res = 0; m_flags = '0; m_wait = 0;
        end else begin
            rdy = m_rdy();
            if (m_wait != 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1; m_res = p_res; m_flags = p_flags;
                end
            end else if (rdy && valid_i) begin
                ref_op(opc, longint'(a), longint'(b), r, f);
                if (opc == 3'd7) begin
                    m_valid = 1'b0; m_wait = N; p_res = r; p_flags = f;
                end else begin
                    m_valid = 1'b1; m_res = r; m_flags = f;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("cmp_valid_o",  valid_o,  m_valid);
            chk("cmp_ready_o",  ready_o,  m_rdy());
            chk("cmp_result_o", result_o, m_res);
            chk("cmp_flags",    flags,    m_flags);
        end
    end

    // Present a request at the next negedge and hold it until the accepting edge; returns 1 ns after it.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        int guard = 0;
        @(negedge clk);
        opc = o; a = x; b = y; valid_i = 1'b1;
        while (!m_rdy()) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                chk("issue_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [2:0] o, input logic [N-1:0] x,
                       input logic [N-1:0] y, input logic [N-1:0] er, input logic [3:0] ef);
        longint r;
        logic [3:0] f;
        ref_op(o, longint'(x), longint'(y), r, f);
        chk({nm, "_model_res"}, r, er);
        chk({nm, "_model_flags"}, f, ef);
        issue(o, x, y);
        chk({nm, "_valid"}, valid_o, 1);
        chk({nm, "_res"}, result_o, er);
        chk({nm, "_flags"}, flags, ef);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_valid",  valid_o,  0);
        chk("rst_result", result_o, 0);
        chk("rst_flags",  flags,    0);
        chk("rst_ready",  ready_o,  1);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", ready_o, 1);

        lit("add_ovf",  3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001);
        lit("sub_zero", 3'd1, 8'h05, 8'h05, 8'h00, 4'b0110);
        lit("sub_brw",  3'd1, 8'h00, 8'h01, 8'hFF, 4'b1000);
        lit("lsl_c",    3'd5, 8'h81, 8'h01, 8'h02, 4'b0010);
        lit("lsr_0",    3'd6, 8'h81, 8'h00, 8'h81, 4'b1000);

        issue(3'd7, 8'h0F, 8'h11);
        chk("mul_ready_busy0", ready_o, 0);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk); #1;
            if (k < N) begin
                chk("mul_valid_early", valid_o, 0);
                chk("mul_ready_busy",  ready_o, 0);
            end
        end
        chk("mul_valid", valid_o,  1);
        chk("mul_res",   result_o, 8'hFF);
        chk("mul_flags", flags,    4'b1000);

        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = N'($urandom); b = N'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", valid_o,  1);
            chk("hold_res",   result_o, 8'hFF);
            chk("hold_flags", flags,    4'b1000);
        end
        ready_i = 1'b1;
        issue(3'd2, 8'hF0, 8'h3C);
        chk("b2b_valid", valid_o,  1);
        chk("b2b_res",   result_o, 8'h30);
        chk("b2b_flags", flags,    4'b0000);
        @(negedge clk);
        valid_i = 1'b0;

        issue(3'd7, 8'hA5, 8'h3C);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid",  valid_o,  0);
        chk("midrst_result", result_o, 0);
        chk("midrst_ready",  ready_o,  1);
        @(negedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", valid_o, 0);
        end

        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            ready_i = ($urandom_range(0, 9) < 7);
            valid_i = $urandom_range(0, 1) == 1;
            opc = 3'($urandom);
            a = N'($urandom);
            b = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 2)) : N'($urandom);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
